// File: rtl/ram_arbiter_ctrl.sv
// ram_arbiter_ctrl
//
// Multi-channel controller in front of a single-port storage array.
// NUM_CH requesters share the array through round-robin arbitration.
// After every reset the whole array is swept to INIT_VAL before any
// request is accepted.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   req_valid  : per-channel request valid
//   req_ready  : per-channel accept (one-hot or zero, combinational)
//   req_we     : per-channel 1 = write, 0 = read
//   req_addr   : flattened addresses, channel c at [c*ADDR_W +: ADDR_W]
//   req_wdata  : flattened write data, channel c at [c*DATA_W +: DATA_W]
//   rsp_valid  : one-cycle pulse, read data valid for that channel
//   rsp_data   : read data shared by all channels, held until next read
//   init_done  : high once the init sweep has finished
//   state_dbg  : current FSM state (0 = INIT, 1 = RUN)
//
// Handshake: a channel's request transfers on the rising edge where both
// req_valid[c] and req_ready[c] are high. While valid is high and not yet
// accepted the requester holds we/addr/wdata stable. req_ready depends on
// req_valid, so requesters must not derive req_valid from req_ready.
// A read accepted at edge N presents rsp_valid/rsp_data between edges N
// and N+1; a write accepted at edge N is visible to a read at edge N+1.

module ram_arbiter_ctrl #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                NUM_CH   = 2,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH-1:0]          req_we,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    output logic [NUM_CH-1:0]          rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       init_done,
    output logic                       state_dbg
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  sweep_cnt;
    logic [PTR_W-1:0]   ptr;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               run_ok;
    logic [NUM_CH-1:0]  grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    int                 cand;

    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    // Grants are suppressed while rst is high so a request presented in
    // the reset cycle is dropped rather than half-executed.
    assign run_ok    = (state == ST_RUN) && !rst;
    assign req_ready = grant;
    assign state_dbg = state;

    // Round-robin search starting at ptr, wrapping modulo NUM_CH.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            if (!grant_any && run_ok && req_valid[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
    end

    // Route the granted channel's command to the array.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
                sel_we    = req_we[c];
                sel_addr  = req_addr[c*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[c*DATA_W +: DATA_W];
            end
        end
    end

    // Storage array: sweep writes during INIT, granted writes during RUN.
    // No reset on the array itself; the sweep provides its contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                mem[sweep_cnt] <= INIT_VAL;
            end else if (grant_any && sel_we) begin
                mem[sel_addr] <= sel_wdata;
            end
        end
    end

    // Control FSM, arbitration pointer and registered read response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
            ptr       <= '0;
            init_done <= 1'b0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                ST_INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    // The write to the last location ends the sweep.
                    if (&sweep_cnt) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (grant_any) begin
                        ptr <= (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
                        if (!sel_we) begin
                            rsp_valid <= grant;
                            rsp_data  <= mem[sel_addr];
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter_ctrl.sv
// Bench for ram_arbiter_ctrl: a default instance (8-bit, 256 words, 2
// channels) and a variant (16-bit, 16 words, 3 channels, INIT 0xBEEF).
module tb_ram_arbiter_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1;
    logic rst1 = 1'b1;

    // ---------------- DUT 0 (defaults) ----------------
    logic [1:0]  v0 = '0, we0 = '0;
    logic [1:0]  rdy0, rv0;
    logic [15:0] addr0 = '0, wd0 = '0;
    logic [7:0]  rd0;
    logic        done0, st0;

    ram_arbiter_ctrl #(.DATA_W(8), .ADDR_W(8), .NUM_CH(2), .INIT_VAL(8'h00)) dut0 (
        .clk(clk), .rst(rst0), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
        .req_addr(addr0), .req_wdata(wd0), .rsp_valid(rv0), .rsp_data(rd0),
        .init_done(done0), .state_dbg(st0)
    );

    // ---------------- DUT 1 (variant) ----------------
    logic [2:0]  v1 = '0, we1 = '0;
    logic [2:0]  rdy1, rv1;
    logic [11:0] addr1 = '0;
    logic [47:0] wd1 = '0;
    logic [15:0] rd1;
    logic        done1, st1;

    ram_arbiter_ctrl #(.DATA_W(16), .ADDR_W(4), .NUM_CH(3), .INIT_VAL(16'hBEEF)) dut1 (
        .clk(clk), .rst(rst1), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
        .req_addr(addr1), .req_wdata(wd1), .rsp_valid(rv1), .rsp_data(rd1),
        .init_done(done1), .state_dbg(st1)
    );

    // ---------------- reference models / scoreboard ----------------
    logic [7:0]  m0 [256];
    logic [15:0] m1 [16];
    int          ptr0 = 0;
    int          ptr1 = 0;
    logic [9:0]  exp0_q [$];   // {rsp_valid one-hot, data}
    logic [18:0] exp1_q [$];
    logic [9:0]  e0;
    logic [18:0] e1;
    int          errors = 0;
    int          checks = 0;

    always @(negedge clk) begin
        if (rv0 !== 2'b00) begin
            checks++;
            if (exp0_q.size() == 0) begin
                errors++;
                $display("FAIL rsp0_unexpected: rsp_valid=%b data=%h, required no response", rv0, rd0);
            end else begin
                e0 = exp0_q.pop_front();
                if ({rv0, rd0} !== e0) begin
                    errors++;
                    $display("FAIL rsp0: rsp_valid=%b data=%h, required rsp_valid=%b data=%h",
                             rv0, rd0, e0[9:8], e0[7:0]);
                end
            end
        end
        if (rv1 !== 3'b000) begin
            checks++;
            if (exp1_q.size() == 0) begin
                errors++;
                $display("FAIL rsp1_unexpected: rsp_valid=%b data=%h, required no response", rv1, rd1);
            end else begin
                e1 = exp1_q.pop_front();
                if ({rv1, rd1} !== e1) begin
                    errors++;
                    $display("FAIL rsp1: rsp_valid=%b data=%h, required rsp_valid=%b data=%h",
                             rv1, rd1, e1[18:16], e1[15:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present a set of requests on dut0; each channel drops valid once granted.
    task automatic batch0(input logic [1:0] mask, input logic [1:0] we,
                          input logic [15:0] addr, input logic [15:0] wd);
        logic [1:0] pend, exp_g;
        int c, cyc;
        pend = mask; v0 = mask; we0 = we; addr0 = addr; wd0 = wd; cyc = 0;
        while (pend != 2'b00 && cyc < 20) begin
            @(negedge clk);
            exp_g = '0;
            for (int i = 0; i < 2; i++) begin
                c = (ptr0 + i) % 2;
                if (exp_g == 2'b00 && pend[c]) exp_g[c] = 1'b1;
            end
            checks++;
            if (rdy0 !== exp_g) begin
                errors++;
                $display("FAIL ready0: req_ready=%b, required %b", rdy0, exp_g);
            end
            for (int k = 0; k < 2; k++) begin
                if (exp_g[k]) begin
                    if (we[k]) m0[addr[k*8 +: 8]] = wd[k*8 +: 8];
                    else exp0_q.push_back({exp_g, m0[addr[k*8 +: 8]]});
                    ptr0 = (k + 1) % 2;
                end
            end
            @(posedge clk); #1;
            pend = pend & ~exp_g;
            v0 = pend;
            cyc++;
        end
        if (pend != 2'b00) begin
            errors++;
            $display("FAIL batch0_timeout: pending=%b, required 00", pend);
            v0 = '0;
        end
    endtask

    task automatic batch1(input logic [2:0] mask, input logic [2:0] we,
                          input logic [11:0] addr, input logic [47:0] wd);
        logic [2:0] pend, exp_g;
        int c, cyc;
        pend = mask; v1 = mask; we1 = we; addr1 = addr; wd1 = wd; cyc = 0;
        while (pend != 3'b000 && cyc < 20) begin
            @(negedge clk);
            exp_g = '0;
            for (int i = 0; i < 3; i++) begin
                c = (ptr1 + i) % 3;
                if (exp_g == 3'b000 && pend[c]) exp_g[c] = 1'b1;
            end
            checks++;
            if (rdy1 !== exp_g) begin
                errors++;
                $display("FAIL ready1: req_ready=%b, required %b", rdy1, exp_g);
            end
            for (int k = 0; k < 3; k++) begin
                if (exp_g[k]) begin
                    if (we[k]) m1[addr[k*4 +: 4]] = wd[k*16 +: 16];
                    else exp1_q.push_back({exp_g, m1[addr[k*4 +: 4]]});
                    ptr1 = (k + 1) % 3;
                end
            end
            @(posedge clk); #1;
            pend = pend & ~exp_g;
            v1 = pend;
            cyc++;
        end
        if (pend != 3'b000) begin
            errors++;
            $display("FAIL batch1_timeout: pending=%b, required 000", pend);
            v1 = '0;
        end
    endtask

    // Release reset and count edges until init_done, holding all valids high.
    task automatic sweep0(output int n, output bit ready_bad);
        @(posedge clk); #1;
        rst0 = 1'b0; v0 = 2'b11; n = 0; ready_bad = 1'b0;
        for (int i = 0; i < 256; i++) m0[i] = 8'h00;
        ptr0 = 0;
        while (done0 !== 1'b1 && n < 400) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (done0 !== 1'b1 && rdy0 !== 2'b00) ready_bad = 1'b1;
        end
        v0 = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic sweep1(output int n, output bit ready_bad);
        @(posedge clk); #1;
        rst1 = 1'b0; v1 = 3'b111; n = 0; ready_bad = 1'b0;
        for (int i = 0; i < 16; i++) m1[i] = 16'hBEEF;
        ptr1 = 0;
        while (done1 !== 1'b1 && n < 100) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (done1 !== 1'b1 && rdy1 !== 3'b000) ready_bad = 1'b1;
        end
        v1 = 3'b000;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        v0 = 2'b11; v1 = 3'b111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 8;
        if (rv0 !== 2'b00)  begin errors++; $display("FAIL reset_rsp_valid0: got %b, required 00", rv0); end
        if (rd0 !== 8'h00)  begin errors++; $display("FAIL reset_rsp_data0: got %h, required 00", rd0); end
        if (done0 !== 1'b0) begin errors++; $display("FAIL reset_init_done0: got %b, required 0", done0); end
        if (rdy0 !== 2'b00) begin errors++; $display("FAIL reset_ready0: got %b, required 00", rdy0); end
        if (st0 !== 1'b0)   begin errors++; $display("FAIL reset_state0: got %b, required 0", st0); end
        if (rv1 !== 3'b000) begin errors++; $display("FAIL reset_rsp_valid1: got %b, required 000", rv1); end
        if (done1 !== 1'b0) begin errors++; $display("FAIL reset_init_done1: got %b, required 0", done1); end
        if (rdy1 !== 3'b000) begin errors++; $display("FAIL reset_ready1: got %b, required 000", rdy1); end
        v0 = 2'b00; v1 = 3'b000;
    endtask

    task automatic test_init_sweep();
        int n;
        bit bad;
        sweep0(n, bad);
        checks += 3;
        if (n != 256) begin errors++; $display("FAIL init_cycles: got %0d edges, required 256", n); end
        if (bad)      begin errors++; $display("FAIL init_ready: ready=1 during sweep, required 0"); end
        if (st0 !== 1'b1) begin errors++; $display("FAIL init_state: got %b, required 1", st0); end
        batch0(2'b01, 2'b00, 16'h0000, 16'h0000);
        batch0(2'b01, 2'b00, 16'h007F, 16'h0000);
        batch0(2'b01, 2'b00, 16'h00FF, 16'h0000);
    endtask

    task automatic test_single_channel();
        batch0(2'b01, 2'b01, 16'h0001, 16'h00FF);
        batch0(2'b01, 2'b00, 16'h0001, 16'h0000);
        @(negedge clk);
        checks++;
        if (rv0 !== 2'b01 || rd0 !== 8'hFF) begin
            errors++;
            $display("FAIL single_read: rsp_valid=%b data=%h, required 01 ff", rv0, rd0);
        end
        @(posedge clk); #1;
        // preload for contention; two ch1 grants leave the pointer at 0
        batch0(2'b10, 2'b10, 16'h0200, 16'hAA00);
        batch0(2'b10, 2'b10, 16'h0300, 16'h1100);
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        v0 = 2'b11; we0 = 2'b00; addr0 = {8'h03, 8'h02};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (rdy0 !== exp_g) begin
                errors++;
                $display("FAIL contention_grant%0d: req_ready=%b, required %b", k, rdy0, exp_g);
            end
            exp0_q.push_back({exp_g, (k % 2 == 0) ? 8'hAA : 8'h11});
            ptr0 = (k % 2 == 0) ? 1 : 0;
            @(posedge clk); #1;
        end
        v0 = 2'b00;
    endtask

    task automatic test_hazard();
        batch0(2'b10, 2'b10, 16'h0400, 16'h5A00);
        batch0(2'b01, 2'b00, 16'h0004, 16'h0000);
        @(negedge clk);
        checks++;
        if (rv0 !== 2'b01 || rd0 !== 8'h5A) begin
            errors++;
            $display("FAIL hazard_read: rsp_valid=%b data=%h, required 01 5a", rv0, rd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] a [4];
        logic [7:0] d;
        for (int k = 0; k < 4; k++) begin
            a[k] = 8'($urandom_range(16, 254));
            d    = 8'($urandom_range(0, 255));
            batch0(2'b10, 2'b10, {a[k], 8'h00}, {d, 8'h00});
        end
        for (int k = 0; k < 4; k++) begin
            batch0(2'b01, 2'b00, {8'h00, a[k]}, 16'h0000);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit bad;
        v0 = 2'b01; we0 = 2'b00; addr0 = 16'h0001;
        @(negedge clk);
        checks++;
        if (rdy0 !== 2'b01) begin errors++; $display("FAIL mid_accept: req_ready=%b, required 01", rdy0); end
        exp0_q.push_back({2'b01, m0[1]});
        @(posedge clk); #1;
        v0 = 2'b11; rst0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (rv0 !== 2'b00)  begin errors++; $display("FAIL mid_rsp_valid: got %b, required 00", rv0); end
        if (done0 !== 1'b0) begin errors++; $display("FAIL mid_init_done: got %b, required 0", done0); end
        if (rdy0 !== 2'b00) begin errors++; $display("FAIL mid_ready: got %b, required 00", rdy0); end
        sweep0(n, bad);
        checks += 2;
        if (n != 256) begin errors++; $display("FAIL mid_resweep: got %0d edges, required 256", n); end
        if (bad)      begin errors++; $display("FAIL mid_resweep_ready: ready=1 during sweep, required 0"); end
        batch0(2'b01, 2'b00, 16'h0001, 16'h0000);
        batch0(2'b10, 2'b00, 16'h0400, 16'h0000);
    endtask

    task automatic test_variant();
        int n;
        bit bad;
        sweep1(n, bad);
        checks += 2;
        if (n != 16) begin errors++; $display("FAIL var_init_cycles: got %0d edges, required 16", n); end
        if (bad)     begin errors++; $display("FAIL var_init_ready: ready=1 during sweep, required 0"); end
        batch1(3'b111, 3'b111, {4'hF, 4'h7, 4'h0}, {16'h9ABC, 16'h5678, 16'h1234});
        batch1(3'b111, 3'b000, {4'h7, 4'h0, 4'hF}, 48'h0);
        batch1(3'b010, 3'b000, {4'h0, 4'h3, 4'h0}, 48'h0);
        @(negedge clk);
        checks++;
        if (rv1 !== 3'b010 || rd1 !== 16'hBEEF) begin
            errors++;
            $display("FAIL var_untouched: rsp_valid=%b data=%h, required 010 beef", rv1, rd1);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_init_sweep();
        test_single_channel();
        test_contention();
        test_hazard();
        test_back_to_back();
        test_reset_mid();
        test_variant();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
            errors++;
            $display("FAIL missing_responses: outstanding %0d/%0d, required 0/0",
                     exp0_q.size(), exp1_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
